// File: rtl/sequenciador_pkg.sv
// rtl/sequenciador_pkg.sv - shared state encodings and default widths for the Simon-style sequencer
package sequenciador_pkg;

  localparam int ST_W          = 4;
  localparam int ADDR_W_DEF    = 4;
  localparam int DATA_W_DEF    = 4;
  localparam int LAST_ADDR_DEF = 15;
  localparam int TIMEOUT_DEF   = 5000;

  typedef enum logic [ST_W-1:0] {
    INICIAL       = 4'd0,
    PREPARA       = 4'd1,
    LE_ROM        = 4'd2,
    ESPERA_JOGADA = 4'd3,
    COMPARA       = 4'd4,
    PROX_JOGADA   = 4'd5,
    PROX_RODADA   = 4'd6,
    FIM_ACERTO    = 4'd7,
    FIM_ERRO      = 4'd8,
    FIM_TIMEOUT   = 4'd9
  } estado_t;

endpackage

// File: rtl/contador_timeout.sv
// rtl/contador_timeout.sv - move timer: up counter with clear, enable and terminal count at TIMEOUT-1
module contador_timeout #(
  parameter int TIMEOUT = 5000,
  parameter int W       = $clog2(TIMEOUT + 1)
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam logic [W-1:0] TERM = W'(TIMEOUT - 1);
  localparam logic [W-1:0] MAX  = W'(TIMEOUT);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // clear has priority; the count stops at TIMEOUT so it can never wrap
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != MAX)) begin
      count_d = count_q + W'(1);
    end
  end

  // count register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign terminal = (count_q == TERM);

endmodule

// File: rtl/sequenciador_memoria.sv
// rtl/sequenciador_memoria.sv - Simon-style game controller reading the pattern ROM and checking player moves
module sequenciador_memoria
  import sequenciador_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int LAST_ADDR = LAST_ADDR_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              iniciar,
  input  logic              jogada_valida,
  input  logic [DATA_W-1:0] jogada,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [DATA_W-1:0] rom_data,
  output logic [ADDR_W-1:0] rodada,
  output logic              pronto,
  output logic              acertou,
  output logic              errou,
  output logic              timeout,
  output logic [ST_W-1:0]   estado_db
);

  localparam int              TMR_W    = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(LAST_ADDR);

  estado_t           estado_q, estado_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] rodada_q, rodada_d;
  logic [DATA_W-1:0] jogada_q, jogada_d;
  logic              jv_q, jv_d;
  logic              pronto_q, pronto_d;
  logic              acertou_q, acertou_d;
  logic              errou_q, errou_d;
  logic              timeout_q, timeout_d;

  logic tmr_clear;
  logic tmr_enable;
  logic tmr_term;
  logic aceita;

  contador_timeout #(
    .TIMEOUT (TIMEOUT),
    .W       (TMR_W)
  ) u_timer (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (tmr_clear),
    .enable   (tmr_enable),
    .terminal (tmr_term)
  );

  // a move counts only on a rising edge of the strobe seen while waiting for it
  assign aceita = (estado_q == ESPERA_JOGADA) && jogada_valida && !jv_q;

  // next-state, counters, move capture and registered outcome flags
  always_comb begin
    estado_d   = estado_q;
    addr_d     = addr_q;
    rodada_d   = rodada_q;
    jogada_d   = jogada_q;
    jv_d       = jogada_valida;
    tmr_clear  = 1'b0;
    tmr_enable = 1'b0;

    case (estado_q)
      INICIAL: begin
        if (iniciar) estado_d = PREPARA;
      end
      PREPARA: begin
        addr_d    = '0;
        rodada_d  = '0;
        tmr_clear = 1'b1;
        estado_d  = LE_ROM;
      end
      LE_ROM: begin
        estado_d = ESPERA_JOGADA;
      end
      ESPERA_JOGADA: begin
        tmr_enable = 1'b1;
        if (aceita) begin
          jogada_d  = jogada;
          tmr_clear = 1'b1;
          estado_d  = COMPARA;
        end else if (tmr_term) begin
          estado_d = FIM_TIMEOUT;
        end
      end
      COMPARA: begin
        if (jogada_q != rom_data) begin
          estado_d = FIM_ERRO;
        end else if (addr_q < rodada_q) begin
          estado_d = PROX_JOGADA;
        end else if (rodada_q < LAST_IDX) begin
          estado_d = PROX_RODADA;
        end else begin
          estado_d = FIM_ACERTO;
        end
      end
      PROX_JOGADA: begin
        addr_d   = addr_q + ADDR_W'(1);
        estado_d = LE_ROM;
      end
      PROX_RODADA: begin
        rodada_d = rodada_q + ADDR_W'(1);
        addr_d   = '0;
        estado_d = LE_ROM;
      end
      FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: begin
        if (iniciar) estado_d = PREPARA;
      end
      default: begin
        estado_d = INICIAL;
      end
    endcase

    // flags follow the state being entered, so they rise together with it
    acertou_d = (estado_d == FIM_ACERTO);
    errou_d   = (estado_d == FIM_ERRO);
    timeout_d = (estado_d == FIM_TIMEOUT);
    pronto_d  = acertou_d || errou_d || timeout_d;
  end

  // state and datapath registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q  <= INICIAL;
      addr_q    <= '0;
      rodada_q  <= '0;
      jogada_q  <= '0;
      jv_q      <= 1'b0;
      pronto_q  <= 1'b0;
      acertou_q <= 1'b0;
      errou_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      addr_q    <= addr_d;
      rodada_q  <= rodada_d;
      jogada_q  <= jogada_d;
      jv_q      <= jv_d;
      pronto_q  <= pronto_d;
      acertou_q <= acertou_d;
      errou_q   <= errou_d;
      timeout_q <= timeout_d;
    end
  end

  assign rom_address = addr_q;
  assign rodada      = rodada_q;
  assign pronto      = pronto_q;
  assign acertou     = acertou_q;
  assign errou       = errou_q;
  assign timeout     = timeout_q;
  assign estado_db   = estado_q;

endmodule

// File: tb/tb_sequenciador_memoria.sv
// tb/tb_sequenciador_memoria.sv - scoreboard bench for sequenciador_memoria with a game-level reference model
module tb_sequenciador_memoria;

  localparam int LAST = 3;
  localparam int TMO  = 10;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       iniciar = 1'b0;
  logic       jogada_valida = 1'b0;
  logic [3:0] jogada = 4'd0;
  logic [3:0] rom_address;
  logic [3:0] rom_data = 4'd0;
  logic [3:0] rodada;
  logic       pronto, acertou, errou, timeout;
  logic [3:0] estado_db;

  sequenciador_memoria #(
    .ADDR_W    (4),
    .DATA_W    (4),
    .LAST_ADDR (LAST),
    .TIMEOUT   (TMO)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .iniciar       (iniciar),
    .jogada_valida (jogada_valida),
    .jogada        (jogada),
    .rom_address   (rom_address),
    .rom_data      (rom_data),
    .rodada        (rodada),
    .pronto        (pronto),
    .acertou       (acertou),
    .errou         (errou),
    .timeout       (timeout),
    .estado_db     (estado_db)
  );

  always #5 clock = ~clock;

  logic [3:0] rom_mem [16];
  initial begin
    for (int i = 0; i < 16; i++) rom_mem[i] = (i < 4) ? 4'(1 << i) : 4'd0;
  end

  // registered ROM: word appears one cycle after the address
  always @(posedge clock) rom_data <= rom_mem[rom_address];

  typedef struct {
    int kind;
    int r;
    int a;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   plan_mv[$];
  int   plan_dl[$];
  logic pronto_prev = 1'b0;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // monitor: every new game-over is matched against the oldest expected outcome
  always @(negedge clock) begin
    if (reset_n && pronto && !pronto_prev) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_end: got state %0d, expected no game end", estado_db);
      end else begin
        mon_e = exp_q.pop_front();
        check("end_state",   int'(estado_db),   mon_e.kind);
        check("end_acertou", int'(acertou),     int'(mon_e.kind == 7));
        check("end_errou",   int'(errou),       int'(mon_e.kind == 8));
        check("end_timeout", int'(timeout),     int'(mon_e.kind == 9));
        check("end_rodada",  int'(rodada),      mon_e.r);
        check("end_address", int'(rom_address), mon_e.a);
      end
    end
    pronto_prev <= pronto;
  end

  task automatic wait_estado(input int s, input int max, input string name);
    for (int i = 0; i < max; i++) begin
      if (int'(estado_db) == s) break;
      @(negedge clock);
    end
    check(name, int'(estado_db), s);
  endtask

  task automatic wait_pronto(input string name);
    for (int i = 0; i < 40; i++) begin
      if (pronto) break;
      @(negedge clock);
    end
    check(name, int'(pronto), 1);
  endtask

  task automatic start_game;
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    check("lat_prepara", int'(estado_db), 1);
    check("flags_clear", int'(pronto), 0);
    @(negedge clock);
    check("lat_le_rom", int'(estado_db), 2);
    @(negedge clock);
    check("lat_espera", int'(estado_db), 3);
    check("start_rodada", int'(rodada), 0);
    check("start_address", int'(rom_address), 0);
  endtask

  task automatic pulse(input int v, input int d);
    repeat (d) @(negedge clock);
    jogada = v[3:0];
    jogada_valida = 1'b1;
    @(negedge clock);
    jogada_valida = 1'b0;
  endtask

  // model: walk rounds 0..LAST, address 0..r, consuming one planned move per step
  task automatic run_plan;
    exp_t e;
    int   n;
    bit   done;
    e = '{7, LAST, LAST};
    n = 0;
    done = 1'b0;
    for (int r = 0; r <= LAST; r++) begin
      for (int i = 0; i <= r; i++) begin
        if (!done) begin
          if (n >= plan_mv.size()) begin
            e = '{9, r, i};
            done = 1'b1;
          end else if (plan_mv[n] != (1 << i)) begin
            e = '{8, r, i};
            n++;
            done = 1'b1;
          end else begin
            n++;
          end
        end
      end
    end
    exp_q.push_back(e);
    start_game();
    for (int k = 0; k < n; k++) begin
      wait_estado(3, 40, "wait_move");
      pulse(plan_mv[k], plan_dl[k]);
    end
    if (e.kind == 9) begin
      wait_estado(3, 40, "wait_idle");
      repeat (TMO - 1) @(negedge clock);
      check("timeout_not_early", int'(timeout), 0);
      check("still_waiting", int'(estado_db), 3);
      @(negedge clock);
      check("timeout_on_time", int'(timeout), 1);
    end
    wait_pronto("game_end");
    @(negedge clock);
  endtask

  task automatic plan_win(input int dmode);
    plan_mv.delete();
    plan_dl.delete();
    for (int r = 0; r <= LAST; r++) begin
      for (int i = 0; i <= r; i++) begin
        plan_mv.push_back(1 << i);
        plan_dl.push_back(dmode < 0 ? int'($urandom_range(0, TMO - 1)) : dmode);
      end
    end
  endtask

  task automatic plan_random;
    int kind, s, step, c;
    plan_mv.delete();
    plan_dl.delete();
    kind = $urandom_range(0, 2);
    s    = $urandom_range(0, 9);
    step = 0;
    for (int r = 0; r <= LAST; r++) begin
      for (int i = 0; i <= r; i++) begin
        c = 1 << i;
        if (kind == 0 || step < s) begin
          plan_mv.push_back(c);
          plan_dl.push_back($urandom_range(0, TMO - 1));
        end else if (kind == 1 && step == s) begin
          plan_mv.push_back(c ^ int'($urandom_range(1, 15)));
          plan_dl.push_back($urandom_range(0, TMO - 1));
        end
        step++;
      end
    end
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge clock);
    check("rst_state",   int'(estado_db),   0);
    check("rst_pronto",  int'(pronto),      0);
    check("rst_acertou", int'(acertou),     0);
    check("rst_errou",   int'(errou),       0);
    check("rst_timeout", int'(timeout),     0);
    check("rst_address", int'(rom_address), 0);
    check("rst_rodada",  int'(rodada),      0);
    reset_n = 1'b1;
    @(negedge clock);

    // full win, immediate moves and moves on the last allowed cycle
    plan_win(0);
    run_plan();
    plan_win(TMO - 1);
    run_plan();

    // wrong second move of round 1
    plan_mv = '{1, 1, 1};
    plan_dl = '{0, 2, 3};
    run_plan();

    // no move at all, then timeout in round 1
    plan_mv.delete();
    plan_dl.delete();
    run_plan();
    plan_mv = '{1};
    plan_dl = '{4};
    run_plan();

    // strobe held high across two waiting visits counts once
    exp_q.push_back('{9, 1, 0});
    start_game();
    jogada = 4'd1;
    jogada_valida = 1'b1;
    @(negedge clock);
    wait_estado(3, 40, "held_second_visit");
    repeat (4) @(negedge clock);
    check("held_no_accept", int'(estado_db), 3);
    check("held_rodada", int'(rodada), 1);
    check("held_address", int'(rom_address), 0);
    jogada_valida = 1'b0;
    wait_pronto("held_end");
    @(negedge clock);

    // asynchronous reset in round 2, then restart
    start_game();
    pulse(1, 0);
    wait_estado(3, 40, "r1_wait");
    pulse(1, 0);
    wait_estado(3, 40, "r1b_wait");
    pulse(2, 0);
    wait_estado(3, 40, "r2_wait");
    pulse(1, 0);
    wait_estado(3, 40, "r2b_wait");
    check("r2_reached", int'(rodada), 2);
    check("r2_address", int'(rom_address), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_state",   int'(estado_db),   0);
    check("arst_rodada",  int'(rodada),      0);
    check("arst_address", int'(rom_address), 0);
    check("arst_pronto",  int'(pronto | acertou | errou | timeout), 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("arst_idle", int'(estado_db), 0);
    plan_win(-1);
    run_plan();

    // randomized games
    for (int g = 0; g < 14; g++) begin
      plan_random();
      run_plan();
    end

    check("pending_outcomes", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sequenciador_memoria.md
Name: sequenciador_memoria

Overview:
Game controller for the 16x4 synchronous pattern ROM, in the style of Simon. In round r it reads ROM addresses 0..r in order and compares each stored pattern with one player move. The game is won when the round at LAST_ADDR is completed. It loses on a mismatch or when the player does not move within TIMEOUT cycles. The block sits between the player-input logic and the ROM and drives the ROM address; the ROM is instantiated outside.

Parameters:
ADDR_W, 4, ROM address width; also the width of the round and address counters.
DATA_W, 4, ROM word and player move width.
LAST_ADDR, 15, final round index; the game is won after round LAST_ADDR is completed.
TIMEOUT, 5000, number of clock cycles allowed per move; must be at least 2.

Ports:
clock  in  1  system clock; all state changes on the rising edge.
reset_n  in  1  asynchronous, active-low reset.
iniciar  in  1  start or restart request; sampled only in INICIAL and the FIM_* states.
jogada_valida  in  1  player move strobe; an internal detector accepts only its 0->1 edges.
jogada  in  DATA_W  player move; captured on an accepted edge.
rom_address  out  ADDR_W  ROM address; equals the internal address counter.
rom_data  in  DATA_W  registered ROM output; valid one cycle after rom_address is applied.
rodada  out  ADDR_W  current round index.
pronto  out  1  game over (any outcome).
acertou  out  1  game won.
errou  out  1  wrong move.
timeout  out  1  move not made in time.
estado_db  out  4  current state encoding, for debug.

Behaviour:
- Reset (reset_n=0, asynchronous): state INICIAL; address counter, rodada, timer, captured move and edge register all 0. pronto, acertou, errou and timeout are 0; rom_address is 0.
- Reset mid-operation behaves the same: outputs go to these values immediately, and no move is kept.
- States and encodings: INICIAL=0, PREPARA=1, LE_ROM=2, ESPERA_JOGADA=3, COMPARA=4, PROX_JOGADA=5, PROX_RODADA=6, FIM_ACERTO=7, FIM_ERRO=8, FIM_TIMEOUT=9. Codes 10-15 are illegal and go to INICIAL.
- INICIAL: go to PREPARA when iniciar=1.
- PREPARA: address counter, rodada and timer set to 0; all flags set to 0; go to LE_ROM.
- LE_ROM: exactly one cycle, so the ROM registers the word at rom_address; go to ESPERA_JOGADA.
- ESPERA_JOGADA:
  - timer increments every cycle.
  - On an accepted edge: capture jogada, clear the timer, go to COMPARA.
  - Else, when timer reaches TIMEOUT-1: go to FIM_TIMEOUT.
  - An edge arriving in the same cycle as the timeout wins.
- COMPARA, comparing the captured move with rom_data:
  - mismatch -> FIM_ERRO.
  - match, and address counter < rodada -> PROX_JOGADA.
  - match, address counter = rodada < LAST_ADDR -> PROX_RODADA.
  - match, address counter = rodada = LAST_ADDR -> FIM_ACERTO.
- PROX_JOGADA: address counter +1; go to LE_ROM.
- PROX_RODADA: rodada +1, address counter set to 0; go to LE_ROM.
- FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT:
  - pronto=1 plus the matching flag (acertou, errou or timeout); flags are registered and asserted on entry.
  - rodada and rom_address are held.
  - iniciar=1 goes to PREPARA.
- iniciar is ignored in all other states.
- Edges of jogada_valida outside ESPERA_JOGADA are discarded, not queued.
- The edge register resets to 0, so a level already high at reset release counts as one edge.
- Latency: with iniciar high at edge k, the FSM is in PREPARA at k+1, LE_ROM at k+2 and ESPERA_JOGADA at k+3.
- An accepted move reaches a flag or the next ESPERA_JOGADA in 1 or 3 cycles.
- Counters never wrap, because LAST_ADDR bounds them. Timer width is clog2(TIMEOUT+1).

Decomposition:
- Package sequenciador_pkg holds the state encodings (4-bit constants), ST_W=4, and the default widths.
- Sub-module contador_timeout: up counter with clear, enable and a terminal-count flag at TIMEOUT-1. It is used for the move timer.
- The edge detector and the two index counters stay inline.

Test Plan:
Bench settings: ROM model with contents addr0=0001, addr1=0010, addr2=0100, addr3=1000; LAST_ADDR=3; TIMEOUT=10.
1. Reset: drive reset_n=0 mid-cycle -> estado_db=0, all flags 0, rom_address=0, rodada=0, without waiting for a clock edge.
2. Full win: iniciar pulse, then the correct 10 moves (rounds 0..3) -> after the last COMPARA, estado_db=7, pronto=1, acertou=1, rodada=3.
3. Error: in round 1, first move 0001 (correct), second move 0001 (expected 0010) -> estado_db=8, errou=1, pronto=1, rodada=1, rom_address=1.
4. Timeout: no move for 10 cycles in ESPERA_JOGADA -> timeout=1, estado_db=9. Repeat with the edge arriving on the 10th cycle -> the move is accepted and no timeout occurs.
5. Held strobe: keep jogada_valida=1 across two consecutive ESPERA_JOGADA visits -> only one move is accepted and the FSM waits in the second visit.
6. Restart: reset_n pulse during round 2 -> INICIAL. Then iniciar -> rodada=0, and the first read is address 0.
